// File: rtl/bin_to_bcd8.sv
// Iterative shift-add-3 binary-to-BCD converter producing eight registered digits.
// Optional BCD_SIGNED_EN macro: treat bin_in as two's complement and report the sign on neg.
module bin_to_bcd8 #(
  parameter int BIN_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             neg,
  output logic [3:0]       num0,
  output logic [3:0]       num1,
  output logic [3:0]       num2,
  output logic [3:0]       num3,
  output logic [3:0]       num4,
  output logic [3:0]       num5,
  output logic [3:0]       num6,
  output logic [3:0]       num7,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(BIN_W + 1);

  // Handshake: start is accepted only on an edge where state is IDLE and busy=0.
  // busy stays high from the accepting edge through the single-cycle done pulse;
  // start seen at any other time is dropped, never queued.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [BIN_W-1:0] opnd;
  logic [31:0]      scratch, adj;
  logic [31:0]      num_r;
  logic [BIN_W-1:0] mag;
  logic             ovf_in, ovf_pend;
  logic             accept;

  assign state_dbg = state;
  assign accept    = (state == S_IDLE) && !busy && start;

`ifdef BCD_SIGNED_EN
  logic sign, neg_pend, neg_r;
  // Negation wraps in BIN_W bits, so the most-negative input maps to 2^(BIN_W-1).
  assign sign = bin_in[BIN_W-1];
  assign mag  = sign ? (~bin_in + BIN_W'(1)) : bin_in;
  assign neg  = neg_r;
`else
  assign mag  = bin_in;
  assign neg  = 1'b0;
`endif

  assign ovf_in = (32'(mag) > 32'd99_999_999);

  always_comb begin
    adj = scratch;
    for (int i = 0; i < 8; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == CW'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
      cnt      <= '0;
      opnd     <= '0;
      scratch  <= '0;
      num_r    <= '0;
`ifdef BCD_SIGNED_EN
      neg_pend <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // IDLE with busy still set is the done cycle; it only clears the handshake.
          if (busy) begin
            busy <= 1'b0;
            done <= 1'b0;
          end else if (start) begin
            opnd     <= mag;
            scratch  <= '0;
            cnt      <= CW'(BIN_W);
            busy     <= 1'b1;
            ovf_pend <= ovf_in;
`ifdef BCD_SIGNED_EN
            neg_pend <= sign;
`endif
          end
        end
        S_SHIFT: begin
          {scratch, opnd} <= {adj[30:0], opnd, 1'b0};
          cnt             <= cnt - CW'(1);
        end
        S_DONE: begin
          num_r <= ovf_pend ? 32'h9999_9999 : scratch;
          ovf   <= ovf_pend;
          done  <= 1'b1;
`ifdef BCD_SIGNED_EN
          neg_r <= neg_pend;
`endif
        end
        default: ;
      endcase
    end
  end

  assign {num7, num6, num5, num4, num3, num2, num1, num0} = num_r;

endmodule
